// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction constants and clog2 helper for the modulo-N counter
package counter_pkg;

    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled cycles by TICK_DIV into a one-cycle step strobe
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_sync_clr,
    output logic o_step
);

    localparam int            PW   = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // With TICK_DIV==1 the phase register never leaves 0 and o_step is just i_en.
    assign o_step = i_en && ((TICK_DIV == 1) || (pre_q == LAST));

    always_comb begin
        pre_d = pre_q;
        if (i_sync_clr) begin
            pre_d = '0;
        end else if (o_step) begin
            pre_d = '0;
        end else if (i_en) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/counter_mod_n.sv
// rtl/counter_mod_n.sv - modulo-N up/down counter with load, clear, prescaler and cascade strobe
// COUNTER_MOD_N_SAT_EN selects saturating instead of wrap-around counting.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int MOD      = 100,
    parameter int WIDTH    = 7,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             dir_up;
    logic             at_limit;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .i_sync_clr (i_clear | i_load),
        .o_step     (step)
    );

    assign dir_up   = (i_up_down == CNT_DIR_UP);
    assign at_limit = dir_up ? (cnt_q == CNT_MAX) : (cnt_q == '0);
    assign o_tc     = step && at_limit;
    assign o_cnt    = cnt_q;
    assign o_wrap   = wrap_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = (i_load_val > CNT_MAX) ? CNT_MAX : i_load_val;
        end else if (step) begin
            if (at_limit) begin
`ifdef COUNTER_MOD_N_SAT_EN
                cnt_d = cnt_q;
`else
                cnt_d  = dir_up ? '0 : CNT_MAX;
                wrap_d = 1'b1;
`endif
            end else begin
                cnt_d = dir_up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule
